// File: rtl/ac3_bank.sv
// ac3_bank: third-stage accumulator bank for the SMAC dot-product datapath.
// NACC independent signed accumulators (OW bits each). Each one has its own operand
// counter and saturation flag. Operand beats carry NACC packed lanes, and only lane
// in_sel is consumed. A beat flagged last pushes the completed sum into a one-entry
// valid/ready output slot and clears that accumulator.
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   in_valid/in_ready        operand handshake; in_ready never depends on in_valid
//   in_sel, in_data, in_last target accumulator, packed signed lanes, final-operand flag
//   clr                      sync clear of accumulators, counters, flags and err_ovf
//   sat_en                   1 = saturating add, 0 = wrap
//   out_valid/out_ready      result handshake
//   out_data/out_idx         completed sum and the accumulator that produced it
//   out_count/out_sat        operand count (capped at MNO), saturation seen
//   err_ovf                  sticky: operand accepted while its counter was at MNO
module ac3_bank #(
    parameter int M    = 16,
    parameter int Pa   = 8,
    parameter int Pw   = 4,
    parameter int MNO  = 288,
    parameter int NACC = 4,
    localparam int IW  = $clog2(M) + Pa + Pw + 1,
    localparam int OW  = IW + $clog2(MNO),
    localparam int SW  = $clog2(NACC),
    localparam int CW  = $clog2(MNO + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SW-1:0]        in_sel,
    input  logic [NACC*IW-1:0]   in_data,
    input  logic                 in_last,
    input  logic                 clr,
    input  logic                 sat_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OW-1:0]        out_data,
    output logic [SW-1:0]        out_idx,
    output logic [CW-1:0]        out_count,
    output logic                 out_sat,
    output logic                 err_ovf
);

    typedef enum logic {S_EMPTY, S_FULL} slot_t;

    logic [OW-1:0] r_acc  [NACC];
    logic [CW-1:0] r_cnt  [NACC];
    logic          r_satf [NACC];
    logic          r_err;
    slot_t         r_state;

    logic [IW-1:0] w_lane;
    logic [OW-1:0] w_ext;
    logic [OW-1:0] w_acc_sel;
    logic [OW:0]   w_sum_wide;
    logic          w_wrap_ovf;
    logic          w_ovf;
    logic [OW-1:0] w_sum;
    logic          w_cnt_full;
    logic [CW-1:0] w_cnt_next;
    logic          w_take;
    logic          w_done;

    localparam logic [OW-1:0] SAT_MAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0] SAT_MIN = {1'b1, {(OW-1){1'b0}}};

    assign out_valid = (r_state == S_FULL);
    assign in_ready  = ~clr & (~out_valid | out_ready);
    assign w_take    = in_valid & in_ready;
    assign w_done    = w_take & in_last;
    assign err_ovf   = r_err;

    assign w_lane    = in_data[in_sel*IW +: IW];
    assign w_ext     = {{(OW-IW){w_lane[IW-1]}}, w_lane};
    assign w_acc_sel = r_acc[in_sel];

    // One guard bit: the true sign lives in bit OW, so disagreement with bit OW-1
    // flags overflow and bit OW picks the clamp direction.
    assign w_sum_wide = {w_acc_sel[OW-1], w_acc_sel} + {w_ext[OW-1], w_ext};
    assign w_wrap_ovf = w_sum_wide[OW] ^ w_sum_wide[OW-1];
    assign w_ovf      = sat_en & w_wrap_ovf;
    assign w_sum      = w_ovf ? (w_sum_wide[OW] ? SAT_MIN : SAT_MAX)
                              : w_sum_wide[OW-1:0];

    assign w_cnt_full = (r_cnt[in_sel] == CW'(MNO));
    assign w_cnt_next = w_cnt_full ? CW'(MNO) : r_cnt[in_sel] + 1'b1;

    // Accumulator, counter and flag storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NACC; k++) begin
                r_acc[SW'(k)]  <= '0;
                r_cnt[SW'(k)]  <= '0;
                r_satf[SW'(k)] <= 1'b0;
            end
            r_err <= 1'b0;
        end else if (clr) begin
            for (int unsigned k = 0; k < NACC; k++) begin
                r_acc[SW'(k)]  <= '0;
                r_cnt[SW'(k)]  <= '0;
                r_satf[SW'(k)] <= 1'b0;
            end
            r_err <= 1'b0;
        end else if (w_take) begin
            if (in_last) begin
                r_acc[in_sel]  <= '0;
                r_cnt[in_sel]  <= '0;
                r_satf[in_sel] <= 1'b0;
            end else begin
                r_acc[in_sel]  <= w_sum;
                r_cnt[in_sel]  <= w_cnt_next;
                r_satf[in_sel] <= r_satf[in_sel] | w_ovf;
            end
            if (w_cnt_full)
                r_err <= 1'b1;
        end
    end

    // Output slot: a completion can only land in FULL when out_ready=1 (in_ready
    // gates it), so a completion always (re)loads and otherwise out_ready drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_EMPTY;
            out_data  <= '0;
            out_idx   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_done)
                        r_state <= S_FULL;
                end
                S_FULL: begin
                    if (!w_done && out_ready)
                        r_state <= S_EMPTY;
                end
                default: r_state <= S_EMPTY;
            endcase
            if (w_done) begin
                out_data  <= w_sum;
                out_idx   <= in_sel;
                out_count <= w_cnt_next;
                out_sat   <= r_satf[in_sel] | w_ovf;
            end
        end
    end

endmodule

// File: tb/tb_ac3_bank.sv
module tb_ac3_bank;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_sel;
    logic [67:0]        in_data;
    logic               in_last;
    logic               clr;
    logic               sat_en;
    logic               out_valid;
    logic               out_ready;
    logic signed [25:0] out_data;
    logic [1:0]         out_idx;
    logic [8:0]         out_count;
    logic               out_sat;
    logic               err_ovf;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ac3_bank #(.M(16), .Pa(8), .Pw(4), .MNO(288), .NACC(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .in_last   (in_last),
        .clr       (clr),
        .sat_en    (sat_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_count (out_count),
        .out_sat   (out_sat),
        .err_ovf   (err_ovf)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Non-selected lanes carry junk so that only lane in_sel may be consumed.
    task automatic set_lane(input int sel, input int val);
        in_data = {4{17'h0F0F3}};
        in_data[sel*17 +: 17] = 17'(val);
        in_sel = 2'(sel);
    endtask

    task automatic beat(input int sel, input int val, input bit last);
        set_lane(sel, val);
        in_last  = last;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic chk_out(input string tag, input int data, input int idx, input int cnt,
                           input bit sat);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"},  out_data,  data);
        chk({tag, "_idx"},   out_idx,   idx);
        chk({tag, "_count"}, out_count, cnt);
        chk({tag, "_sat"},   out_sat,   sat);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; in_last = 1'b0;
        clr = 1'b0; sat_en = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data",  out_data,  0);
        chk("rst_idx",   out_idx,   0);
        chk("rst_count", out_count, 0);
        chk("rst_sat",   out_sat,   0);
        chk("rst_err",   err_ovf,   0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_ready", in_ready, 1);

        // Basic accumulation on acc0
        beat(0, 5, 0);
        chk("nolast_valid", out_valid, 0);
        beat(0, -3, 0);
        beat(0, 10, 1);
        chk_out("t1", 12, 0, 3, 0);

        // Interleaved acc1 / acc3, back-to-back completions
        beat(1, 100, 0);
        chk("drain_valid", out_valid, 0);
        beat(3, -7, 0);
        beat(1, 200, 1);
        chk_out("t2a", 300, 1, 2, 0);
        beat(3, -1, 1);
        chk_out("t2b", -8, 3, 2, 0);
        beat(2, 4, 1);
        chk_out("t2c", 4, 2, 1, 0);
        beat(0, -2, 1);
        chk_out("t2d", -2, 0, 1, 0);

        // Backpressure: hold slot, then reload in the same cycle as out_ready
        beat(2, 6, 1);
        out_ready = 1'b0;
        set_lane(0, 50);
        in_last  = 1'b1;
        in_valid = 1'b1;
        #1;
        chk("bp_ready0", in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_data",  out_data, 6);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk_out("reload", 50, 0, 1, 0);
        @(posedge clk); #1;
        chk("empty_valid", out_valid, 0);

        // Saturation and counter overflow on acc2
        sat_en = 1'b1;
        for (int i = 0; i < 513; i++) beat(2, 65535, i == 512);
        chk_out("sat", 33554431, 2, 288, 1);
        chk("sat_err", err_ovf, 1);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("clr_err", err_ovf, 0);
        sat_en = 1'b0;
        for (int i = 0; i < 513; i++) beat(2, 65535, i == 512);
        chk_out("wrap", -33489409, 2, 288, 0);
        chk("wrap_err", err_ovf, 1);

        // clr discards partial sum and blocks the concurrent beat
        for (int i = 0; i < 4; i++) beat(0, 10, 0);
        set_lane(0, 7);
        in_last  = 1'b1;
        in_valid = 1'b1;
        clr      = 1'b1;
        #1;
        chk("clr_ready", in_ready, 0);
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        chk("clr_valid", out_valid, 0);
        chk("clr_err2",  err_ovf, 0);
        beat(0, 9, 1);
        chk_out("postclr", 9, 0, 1, 0);

        // clr leaves a FULL slot alone
        beat(1, 3, 1);
        out_ready = 1'b0;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk_out("clrfull", 3, 1, 1, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Async reset while a result is FULL and acc1 holds 77
        beat(1, 77, 0);
        beat(0, 5, 1);
        out_ready = 1'b0;
        chk("prerst_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data",  out_data, 0);
        chk("arst_count", out_count, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        beat(1, 1, 1);
        chk_out("postrst", 1, 1, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
